alu_share_arbiter: RTL and testbench

- Shares one dual-mode ALU datapath between two requesters.
- The datapath runs either as one 8-bit ALU or as two independent 4-bit ALUs.
- The block arbitrates round-robin, captures the winner's operands, runs one ALU operation and returns a registered result with flags. The result is held until the winner accepts it.
- Sits between two tile-level clients (e.g. a host bit-serial loader and a self-test sequencer) and the ALU core.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_lane_core.sv | 43 ++++
 rtl/alu_share_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the shared dual-mode ALU arbiter: opcodes, FSM states and lane modes.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SHL = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_NOT = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  localparam logic MODE_FULL = 1'b0;
  localparam logic MODE_DUAL = 1'b1;

endpackage

// File: rtl/alu_lane_core.sv
// Combinational ALU lane of parameterised width; returns result and carry/borrow.
module alu_lane_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_res,
  output logic         o_carry
);

  logic [W:0] w_sum;
  logic [W:0] w_diff;

  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  // The extra top bit of the widened difference is the unsigned borrow.
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

  always_comb begin
    o_res   = '0;
    o_carry = 1'b0;
    case (i_op)
      OP_ADD: begin
        o_res   = w_sum[W-1:0];
        o_carry = w_sum[W];
      end
      OP_SUB: begin
        o_res   = w_diff[W-1:0];
        o_carry = w_diff[W];
      end
      OP_AND:  o_res = i_a & i_b;
      OP_OR:   o_res = i_a | i_b;
      OP_XOR:  o_res = i_a ^ i_b;
      OP_SHL:  o_res = {i_a[W-2:0], 1'b0};
      OP_SHR:  o_res = {1'b0, i_a[W-1:1]};
      OP_NOT:  o_res = ~i_a;
      default: o_res = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one full-width / dual half-width ALU between two requesters,
// returning a registered result that is held until the winner accepts it.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_req_valid,
  output logic [1:0]            o_req_ready,
  input  logic [2*DATA_W-1:0]   i_req_a,
  input  logic [2*DATA_W-1:0]   i_req_b,
  input  logic [5:0]            i_req_op,
  input  logic [1:0]            i_req_mode,
  output logic [1:0]            o_rsp_valid,
  input  logic [1:0]            i_rsp_ready,
  output logic [DATA_W-1:0]     o_rsp_data,
  output logic [1:0]            o_rsp_carry,
  output logic                  o_rsp_zero,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_op_count
);

  localparam int unsigned HALF_W = DATA_W / 2;

  state_e              r_state;
  state_e              w_state_next;
  logic                r_last_grant;
  logic                r_grant;
  logic                w_grant;
  logic                w_req_fire;
  logic                w_rsp_fire;

  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [2:0]          r_op;
  logic                r_mode;

  logic [DATA_W-1:0]   w_sel_a;
  logic [DATA_W-1:0]   w_sel_b;
  logic [2:0]          w_sel_op;
  logic                w_sel_mode;

  logic [DATA_W-1:0]   r_rsp_data;
  logic [1:0]          r_rsp_carry;
  logic                r_rsp_zero;
  logic [CNT_W-1:0]    r_op_count;

  logic [DATA_W-1:0]   w_full_res;
  logic                w_full_carry;
  logic [HALF_W-1:0]   w_lo_res;
  logic                w_lo_carry;
  logic [HALF_W-1:0]   w_hi_res;
  logic                w_hi_carry;
  logic [DATA_W-1:0]   w_alu_data;
  logic [1:0]          w_alu_carry;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    w_grant = 1'b0;
    if (&i_req_valid) begin
      w_grant = ~r_last_grant;
    end else begin
      w_grant = ~i_req_valid[0];
    end
  end

  always_comb begin
    w_sel_a    = w_grant ? i_req_a[2*DATA_W-1:DATA_W] : i_req_a[DATA_W-1:0];
    w_sel_b    = w_grant ? i_req_b[2*DATA_W-1:DATA_W] : i_req_b[DATA_W-1:0];
    w_sel_op   = w_grant ? i_req_op[5:3] : i_req_op[2:0];
    w_sel_mode = w_grant ? i_req_mode[1] : i_req_mode[0];
  end

  always_comb begin
    w_state_next = r_state;
    o_req_ready  = 2'b00;
    w_req_fire   = 1'b0;
    w_rsp_fire   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_req_valid[w_grant]) begin
          o_req_ready[w_grant] = 1'b1;
          w_req_fire           = 1'b1;
          w_state_next         = StExec;
        end
      end
      StExec: w_state_next = StResp;
      StResp: begin
        if (i_rsp_ready[r_grant]) begin
          w_rsp_fire   = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  alu_lane_core #(
    .W (DATA_W)
  ) u_full (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_res   (w_full_res),
    .o_carry (w_full_carry)
  );

  alu_lane_core #(
    .W (HALF_W)
  ) u_lo (
    .i_a     (r_a[HALF_W-1:0]),
    .i_b     (r_b[HALF_W-1:0]),
    .i_op    (r_op),
    .o_res   (w_lo_res),
    .o_carry (w_lo_carry)
  );

  alu_lane_core #(
    .W (HALF_W)
  ) u_hi (
    .i_a     (r_a[DATA_W-1:HALF_W]),
    .i_b     (r_b[DATA_W-1:HALF_W]),
    .i_op    (r_op),
    .o_res   (w_hi_res),
    .o_carry (w_hi_carry)
  );

  always_comb begin
    if (r_mode == MODE_DUAL) begin
      w_alu_data  = {w_hi_res, w_lo_res};
      w_alu_carry = {w_hi_carry, w_lo_carry};
    end else begin
      w_alu_data  = w_full_res;
      w_alu_carry = {1'b0, w_full_carry};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b1;
      r_grant      <= 1'b0;
      r_a          <= '0;
      r_b          <= '0;
      r_op         <= OP_ADD;
      r_mode       <= MODE_FULL;
      r_rsp_data   <= '0;
      r_rsp_carry  <= 2'b00;
      r_rsp_zero   <= 1'b0;
      r_op_count   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_req_fire) begin
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        r_op         <= w_sel_op;
        r_mode       <= w_sel_mode;
      end
      if (r_state == StExec) begin
        r_rsp_data  <= w_alu_data;
        r_rsp_carry <= w_alu_carry;
        r_rsp_zero  <= (w_alu_data == '0);
      end
      if (w_rsp_fire) begin
        r_op_count <= r_op_count + CNT_W'(1);
      end
    end
  end

  assign o_rsp_valid = (r_state == StResp) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_carry = r_rsp_carry;
  assign o_rsp_zero  = r_rsp_zero;
  assign o_busy      = (r_state != StIdle);
  assign o_op_count  = r_op_count;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised bench for alu_share_arbiter against an arithmetic reference model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic [5:0]  req_op;
  logic [1:0]  req_mode;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_carry;
  logic        rsp_zero;
  logic        busy;
  logic [15:0] op_count;

  int n_total = 0;
  int n_bad   = 0;
  int exp_last;
  int exp_cnt;

  alu_share_arbiter #(
    .DATA_W (8),
    .CNT_W  (16)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_op    (req_op),
    .i_req_mode  (req_mode),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_data  (rsp_data),
    .o_rsp_carry (rsp_carry),
    .o_rsp_zero  (rsp_zero),
    .o_busy      (busy),
    .o_op_count  (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lane(input int x, input int y, input int op, input int w,
                              output int c);
    int m;
    int r;
    m = (1 << w) - 1;
    c = 0;
    r = 0;
    case (op)
      0: begin r = x + y; c = r >> w; r = r & m; end
      1: begin c = (x < y) ? 1 : 0; r = (x - y + m + 1) & m; end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = (x * 2) & m;
      6: r = x / 2;
      default: r = m - x;
    endcase
    return r;
  endfunction

  function automatic void ref_alu(input int a, input int b, input int op, input int mode,
                                  output int data, output int carry);
    int lo, hi, clo, chi;
    if (mode == 1) begin
      lo    = lane(a % 16, b % 16, op, 4, clo);
      hi    = lane(a / 16, b / 16, op, 4, chi);
      data  = hi * 16 + lo;
      carry = chi * 2 + clo;
    end else begin
      data  = lane(a, b, op, 8, clo);
      carry = clo;
    end
  endfunction

  task automatic scramble();
    req_valid = 2'($urandom_range(0, 3));
    req_a     = 16'($urandom);
    req_b     = 16'($urandom);
    req_op    = 6'($urandom);
    req_mode  = 2'($urandom);
  endtask

  // Entered and left at a negedge; one full request/response transaction.
  task automatic run_round(input logic [1:0] vld, input logic [15:0] a, input logic [15:0] b,
                           input logic [5:0] op, input logic [1:0] mode, input int hold);
    int w, ed, ec, wa, wb, wop, wmd;
    logic [1:0] onehot, other;
    w = (vld == 2'b11) ? (1 - exp_last) : (vld[0] ? 0 : 1);
    onehot = (w == 1) ? 2'b10 : 2'b01;
    other  = ~onehot;
    req_valid = vld;
    req_a     = a;
    req_b     = b;
    req_op    = op;
    req_mode  = mode;
    rsp_ready = 2'b00;
    wa  = (w == 1) ? int'(a[15:8]) : int'(a[7:0]);
    wb  = (w == 1) ? int'(b[15:8]) : int'(b[7:0]);
    wop = (w == 1) ? int'(op[5:3]) : int'(op[2:0]);
    wmd = int'(mode[w]);
    ref_alu(wa, wb, wop, wmd, ed, ec);
    #1;
    check_eq("req_ready", 32'(req_ready), 32'(onehot));
    @(posedge clk);
    exp_last = w;
    @(negedge clk);
    scramble();
    check_eq("exec_busy", 32'(busy), 32'd1);
    check_eq("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check_eq("rsp_valid", 32'(rsp_valid), 32'(onehot));
    check_eq("rsp_data", 32'(rsp_data), 32'(ed));
    check_eq("rsp_carry", 32'(rsp_carry), 32'(ec));
    check_eq("rsp_zero", 32'(rsp_zero), (ed == 0) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      rsp_ready = other;
      scramble();
      @(negedge clk);
      check_eq("hold_rsp_valid", 32'(rsp_valid), 32'(onehot));
      check_eq("hold_rsp_data", 32'(rsp_data), 32'(ed));
      check_eq("hold_req_ready", 32'(req_ready), 32'd0);
      check_eq("hold_op_count", 32'(op_count), 32'(exp_cnt));
    end
    rsp_ready = onehot | 2'($urandom_range(0, 3));
    req_valid = 2'b00;
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % 65536;
    check_eq("done_op_count", 32'(op_count), 32'(exp_cnt));
    check_eq("done_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("done_busy", 32'(busy), 32'd0);
    rsp_ready = 2'b00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_mode  = '0;
    rsp_ready = 2'b00;
    exp_last  = 1;
    exp_cnt   = 0;
    repeat (2) @(negedge clk);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
    check_eq("rst_rsp_carry", 32'(rsp_carry), 32'd0);
    check_eq("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_op_count", 32'(op_count), 32'd0);
    rst = 1'b0;

    // Tie right after reset: requester 0 (ADD full F0+20), then requester 1 (ADD dual 9F+11).
    run_round(2'b11, 16'h9FF0, 16'h1120, 6'o00, 2'b10, 0);
    check_eq("first_data", 32'(u_dut.o_rsp_data), 32'h10);
    run_round(2'b11, 16'h9FF0, 16'h1120, 6'o00, 2'b10, 0);
    check_eq("dual_data", 32'(rsp_data), 32'hA0);
    check_eq("two_ops", 32'(op_count), 32'd2);

    // SUB borrow with a five-cycle response stall, then SUB to zero.
    run_round(2'b01, 16'h0005, 16'h0006, 6'o01, 2'b00, 5);
    run_round(2'b01, 16'h0033, 16'h0033, 6'o01, 2'b00, 1);

    // Request withdrawn before the edge: nothing is latched.
    req_valid = 2'b01;
    #1;
    check_eq("drop_ready", 32'(req_ready), 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    check_eq("drop_busy", 32'(busy), 32'd0);

    // Reset while in EXEC discards the operation.
    req_valid = 2'b10;
    req_a     = 16'h1234;
    req_b     = 16'h5678;
    req_op    = 6'o00;
    req_mode  = 2'b00;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    rst      = 1'b0;
    exp_last = 1;
    exp_cnt  = 0;
    check_eq("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("rx_busy", 32'(busy), 32'd0);
    check_eq("rx_op_count", 32'(op_count), 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("rx_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_round(2'b11, 16'hFF01, 16'h0102, 6'o34, 2'b01, 0);

    for (int k = 0; k < 60; k++) begin
      run_round(2'($urandom_range(1, 3)), 16'($urandom), 16'($urandom), 6'($urandom),
                2'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
